// File: rtl/crowd_word_tx.sv
// Burst word generator for the two-group BCD crowd counter, with a built-in
// mirror of the counter's digits and sticky warning for cycle-level comparison.
module crowd_word_tx #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       group,
    input  logic       dir,
    input  logic [3:0] count,
    input  logic       inject_bad,
    output logic [4:0] word,
    output logic       sel_out,
    output logic       mode_out,
    output logic       word_valid,
    output logic       busy,
    output logic       done,
    output logic [7:0] exp_h1,
    output logic [7:0] exp_h0,
    output logic [7:0] exp_n1,
    output logic [7:0] exp_n0,
    output logic       exp_warning
);

    typedef enum logic [1:0] {IDLE, SEND, BAD, DONE} state_t;

    localparam logic [4:0] BAD_WORD = 5'b10101;

    state_t     state, next_state;
    logic       grp_q, dir_q, bad_q;
    logic [3:0] rem_q;
    logic [7:0] lfsr;
    logic       accept, grp_n, dir_n;
    logic [4:0] word_n;
    logic       sel_n, mode_n, valid_n, busy_n, done_n;

    assign accept = (state == IDLE) && start;
    assign grp_n  = accept ? group : grp_q;
    assign dir_n  = accept ? dir   : dir_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            grp_q <= 1'b0;
            dir_q <= 1'b0;
            bad_q <= 1'b0;
            rem_q <= '0;
            lfsr  <= SEED;
        end else begin
            state <= next_state;
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (accept) begin
                grp_q <= group;
                dir_q <= dir;
                bad_q <= inject_bad;
                rem_q <= count;
            end else if (state == SEND) begin
                rem_q <= rem_q - 4'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count != 4'd0)  next_state = SEND;
                    else if (inject_bad) next_state = BAD;
                    else                 next_state = DONE;
                end
            end
            SEND: begin
                if (rem_q == 4'd1) next_state = bad_q ? BAD : DONE;
            end
            BAD:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered, so each word lines up
    // with the state that produced it and nothing reaches a port combinationally.
    always_comb begin
        word_n  = '0;
        sel_n   = 1'b0;
        mode_n  = 1'b0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (next_state)
            SEND: begin
                word_n  = {lfsr[4:2], grp_n, grp_n};
                sel_n   = grp_n;
                mode_n  = dir_n;
                valid_n = 1'b1;
                busy_n  = 1'b1;
            end
            BAD: begin
                word_n  = BAD_WORD;
                sel_n   = grp_n;
                mode_n  = dir_n;
                valid_n = 1'b1;
                busy_n  = 1'b1;
            end
            DONE:    done_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            word       <= '0;
            sel_out    <= 1'b0;
            mode_out   <= 1'b0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            word       <= word_n;
            sel_out    <= sel_n;
            mode_out   <= mode_n;
            word_valid <= valid_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    // One BCD step on {tens, ones}: saturate at 00 going down, wrap 20 -> 00 going up.
    function automatic logic [15:0] bcd_step(input logic [7:0] t, input logic [7:0] o,
                                             input logic up);
        logic [7:0] tn, on;
        tn = t;
        on = o;
        if (up) begin
            if (t == 8'd2) begin
                tn = '0;
                on = '0;
            end else if (o == 8'd9) begin
                tn = t + 8'd1;
                on = '0;
            end else begin
                on = o + 8'd1;
            end
        end else begin
            if (t == 8'd0 && o == 8'd0) begin
                tn = t;
            end else if (o == 8'd0) begin
                tn = t - 8'd1;
                on = 8'd9;
            end else begin
                on = o - 8'd1;
            end
        end
        return {tn, on};
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exp_h1      <= '0;
            exp_h0      <= '0;
            exp_n1      <= '0;
            exp_n0      <= '0;
            exp_warning <= 1'b0;
        end else if (word_valid) begin
            if (state == BAD) begin
                exp_warning <= 1'b1;
            end else if (grp_q) begin
                {exp_n1, exp_n0} <= bcd_step(exp_n1, exp_n0, dir_q);
            end else begin
                {exp_h1, exp_h0} <= bcd_step(exp_h1, exp_h0, dir_q);
            end
        end
    end

endmodule

// File: tb/tb_crowd_word_tx.sv
// Directed bench for crowd_word_tx: bursts, wrap, saturation, bad-word
// injection, ignored start while busy and reset mid-burst.
module tb_crowd_word_tx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0, group = 1'b0, dir = 1'b0, inject_bad = 1'b0;
    logic [3:0] count = '0;
    logic [4:0] word;
    logic       sel_out, mode_out, word_valid, busy, done, exp_warning;
    logic [7:0] exp_h1, exp_h0, exp_n1, exp_n0;

    int checks = 0;
    int errors = 0;
    int hv = 0, nv = 0;   // model counts in decimal
    bit warn = 0;

    crowd_word_tx #(.SEED(8'hA5)) dut (
        .CLK(CLK), .RST(RST), .start(start), .group(group), .dir(dir),
        .count(count), .inject_bad(inject_bad), .word(word), .sel_out(sel_out),
        .mode_out(mode_out), .word_valid(word_valid), .busy(busy), .done(done),
        .exp_h1(exp_h1), .exp_h0(exp_h0), .exp_n1(exp_n1), .exp_n0(exp_n0),
        .exp_warning(exp_warning)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_mirror(input string tag);
        check({tag, "_h1"}, 32'(exp_h1), 32'(hv / 10));
        check({tag, "_h0"}, 32'(exp_h0), 32'(hv % 10));
        check({tag, "_n1"}, 32'(exp_n1), 32'(nv / 10));
        check({tag, "_n0"}, 32'(exp_n0), 32'(nv % 10));
        check({tag, "_warn"}, 32'(exp_warning), 32'(warn));
    endtask

    function automatic int next_val(input int v, input bit up);
        if (up) return (v == 20) ? 0 : v + 1;
        return (v > 0) ? v - 1 : 0;
    endfunction

    // Full burst; poke raises start mid-burst to confirm it is ignored.
    task automatic burst(input logic g, input logic d, input int n, input logic bad,
                         input logic poke);
        start = 1'b1; group = g; dir = d; count = 4'(n); inject_bad = bad;
        step();
        start = 1'b0; group = ~g; dir = ~d; count = '0; inject_bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("valid", 32'(word_valid), 32'd1);
            check("busy", 32'(busy), 32'd1);
            check("done_lo", 32'(done), 32'd0);
            check("word_grp", 32'(word[1:0]), 32'({g, g}));
            check("sel", 32'(sel_out), 32'(g));
            check("mode", 32'(mode_out), 32'(d));
            check_mirror("mid");
            if (g) nv = next_val(nv, d);
            else   hv = next_val(hv, d);
            if (poke && i == 1) start = 1'b1;
            if (poke && i == 4) start = 1'b0;
            step();
        end
        if (bad) begin
            check("bad_word", 32'(word), 32'h15);
            check("bad_valid", 32'(word_valid), 32'd1);
            check("bad_sel", 32'(sel_out), 32'(g));
            check_mirror("bad");
            warn = 1;
            step();
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_valid", 32'(word_valid), 32'd0);
        check_mirror("end");
        step();
        check("idle_done", 32'(done), 32'd0);
        check("idle_valid", 32'(word_valid), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        check("rst_outputs", 32'({word, sel_out, mode_out, word_valid, busy, done}), 32'd0);
        check_mirror("rst");
        RST = 1'b0;
        repeat (10) step();
        check("idle_valid", 32'(word_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check_mirror("idle");

        burst(1'b0, 1'b0, 5, 1'b0, 1'b0);     // saturate at 00
        burst(1'b0, 1'b1, 12, 1'b0, 1'b0);    // 00 -> 12
        check("h_tens12", 32'(exp_h1), 32'd1);
        check("h_ones12", 32'(exp_h0), 32'd2);
        burst(1'b1, 1'b1, 15, 1'b0, 1'b0);
        burst(1'b1, 1'b1, 15, 1'b0, 1'b0);    // wraps 20 -> 00, ends at 09
        check("n_tens09", 32'(exp_n1), 32'd0);
        check("n_ones09", 32'(exp_n0), 32'd9);
        burst(1'b0, 1'b1, 8, 1'b0, 1'b1);     // start ignored while busy
        burst(1'b0, 1'b1, 0, 1'b0, 1'b0);     // empty burst

        // Reset during word 3 of 8
        start = 1'b1; group = 1'b0; dir = 1'b1; count = 4'd8;
        step();
        start = 1'b0;
        step();
        step();
        check("w3_valid", 32'(word_valid), 32'd1);
        #2 RST = 1'b1;
        #1;
        hv = 0; nv = 0; warn = 0;
        check("abort_outputs", 32'({word, sel_out, mode_out, word_valid, busy, done}), 32'd0);
        check_mirror("abort");
        @(posedge CLK);
        #1 RST = 1'b0;
        step();
        check("abort_idle", 32'(word_valid), 32'd0);

        burst(1'b1, 1'b1, 2, 1'b1, 1'b0);     // two words then the bad one
        check("n_ones2", 32'(exp_n0), 32'd2);
        check("warn_set", 32'(exp_warning), 32'd1);
        burst(1'b0, 1'b1, 3, 1'b0, 1'b0);
        check("warn_sticky", 32'(exp_warning), 32'd1);
        burst(1'b1, 1'b0, 0, 1'b1, 1'b0);     // bad word only

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crowd_word_tx.md
# crowd_word_tx

Transmitter side of the crowd-counter word interface. Accepts a burst command (group, direction, word count) and emits a stream of 5-bit words with `selection` and `mode` that the two-group BCD crowd counter accepts as valid. An optional deliberately invalid word can be appended to each burst. A built-in mirror of the counter's BCD state and warning flag lets the integration bench compare against the downstream counter cycle by cycle.

## Interface
- `SEED`, 8'hA5: LFSR reset value; must be non-zero.
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `start` input 1: burst request; sampled only in IDLE.
- `group` input 1: target group (0 = hipsterians, 1 = nerdians).
- `dir` input 1: 0 = decrement, 1 = increment.
- `count` input 4: number of valid words in the burst (0..15).
- `inject_bad` input 1: append one invalid word after the valid words.
- `word` output 5: word to the counter.
- `sel_out` output 1: selection to the counter.
- `mode_out` output 1: mode to the counter.
- `word_valid` output 1: downstream advances only on cycles where this is 1 (used as its clock enable).
- `busy` output 1: burst in progress.
- `done` output 1: one-cycle pulse at burst end.
- `exp_h1`, `exp_h0`, `exp_n1`, `exp_n0` output 8 each: mirror BCD tens and ones per group.
- `exp_warning` output 1: mirror of the sticky warning.

## Operation
- FSM states: IDLE, SEND, BAD, DONE.
- IDLE:
  - `start=1` latches `group`, `dir`, `count` and `inject_bad`.
  - `count>0`: go to SEND with remaining count = `count`.
  - `count=0` and `inject_bad=1`: go to BAD.
  - Otherwise: go to DONE.
- SEND:
  - Outputs one valid word per cycle.
  - Remaining count decrements each cycle.
  - At remaining count 1: go to BAD if `inject_bad`, else DONE.
- BAD: outputs one invalid word, then goes to DONE.
- DONE: `done=1` for one cycle, then return to IDLE.
- `start` is ignored outside IDLE.
- Valid word: `word[4:2] = lfsr[4:2]`, `word[1:0] = {g,g}`. The first adjacent pair checked by the counter always equals the group bit, so every generated valid word is accepted.
- Invalid word: fixed 5'b10101. It has no equal adjacent pair, so it is invalid for either group.
- `sel_out` = latched group and `mode_out` = latched dir for every word in the burst.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4 (x^8+x^6+x^5+x^4+1).
  - Shifts every cycle, including IDLE.
  - Loads `SEED` on reset.
- Mirror update, at the edge that ends each `word_valid` cycle, on the selected group's digits (T = tens, O = ones):
  - Valid word, decrement:
    - T=0, O=0: hold (saturate at 00).
    - O=0, T>0: T-1, O=9.
    - Otherwise: O-1.
  - Valid word, increment:
    - T=2: wrap to T=0, O=0 (20 → 00).
    - O=9: T+1, O=0.
    - Otherwise: O+1.
  - Invalid word: digits unchanged; `exp_warning` set and held until reset.
- The other group's digits never change during a burst.

## Timing
- Reset values:
  - State IDLE, lfsr=`SEED`, `word`=0, `sel_out`=0, `mode_out`=0.
  - `word_valid`=0, `busy`=0, `done`=0.
  - All `exp_*` digits = 0, `exp_warning`=0.
- `start` sampled at edge k: first word presented with `word_valid=1` in the cycle after edge k.
- Words are back-to-back, one per cycle, with no gaps.
- `busy=1` from the cycle after edge k through the last word cycle.
- `done=1` in the cycle after the last word, with `busy=0` in that cycle.
- A new `start` is accepted at the earliest in the first IDLE cycle after `done`.
- `count=0` with no injection: `done` pulses in the cycle after edge k and no word is emitted.
- All outputs are registered; no combinational path from inputs to outputs.
- `RST` mid-burst: all outputs return to reset values immediately (asynchronously), the burst is aborted and the mirror is cleared.

## Test plan
- Reset then idle 10 cycles → `word_valid`=0, all `exp_*`=0, `busy`=0, `done`=0.
- start, group=0, dir=1, count=12 from 00:
  - 12 consecutive `word_valid` cycles, each with `word[1:0]`=00 and `sel_out`=0.
  - Afterwards `exp_h1`=1, `exp_h0`=2; `done` pulse one cycle after the last word.
- Wrap-around, group=1, dir=1: bursts of count=15 then count=15 → nerdians reach 20 after 20 words, wrap to 00 on word 21, end at 09; `exp_n1`=0, `exp_n0`=9.
- Saturate, group=0, dir=0, count=5 from 00 → `exp_h*` stay 00 throughout; all 5 words have `word[1:0]`=00.
- inject_bad=1, count=2, group=1, dir=1 from 00:
  - Two valid words, then `word`=5'b10101.
  - Ends with `exp_n0`=2 and `exp_warning`=1.
  - Subsequent clean bursts leave `exp_warning`=1.
- start pulsed while busy during a count=8 burst → ignored; exactly 8 words emitted.
- `RST` asserted at word 3 of 8 → next cycle all outputs zero and state IDLE.
